// File: rtl/rifl_arb_pkg.sv
// Shared types and helpers for the RIFL stream arbiters.
// Holds the arbiter state encoding and the modulo-N pointer advance.
package rifl_arb_pkg;

    // Two-state packet lock: IDLE means no packet is open.
    // LOCKED means the granted source owns the output until its tlast beat.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Advance a round-robin pointer by one, wrapping at n.
    // The wrap uses an explicit compare, so n does not have to be a power of two.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        if (ptr + 32'd1 >= n) begin
            return 32'd0;
        end
        return ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rifl_rr_pick.sv
// Combinational rotating priority encoder.
// It returns the first requester found by scanning from ptr upward, modulo N_SRC.
// It has no state, so other RIFL schedulers can reuse it.
module rifl_rr_pick
    import rifl_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IDW   = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   idx,
    output logic             found
);

    int unsigned cand;

    // Scan ptr, ptr+1, ... with wrap, and latch the first active request.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 32'(ptr);
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && req[cand[IDW-1:0]]) begin
                idx   = cand[IDW-1:0];
                found = 1'b1;
            end
            cand = rr_next(cand, N_SRC);
        end
    end

endmodule

// File: rtl/rifl_axis_rr_arbiter.sv
// Packet-atomic round-robin merge of N_SRC AXI-Stream sources into one registered output.
// A winning source keeps the grant until its tlast beat is accepted.
// m_axis_tid carries the index of the source that produced each beat.
module rifl_axis_rr_arbiter
    import rifl_arb_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DWIDTH = 32,
    parameter int IDW    = $clog2(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC*DWIDTH-1:0]     s_axis_tdata,
    input  logic [N_SRC*DWIDTH/8-1:0]   s_axis_tkeep,
    input  logic [N_SRC-1:0]            s_axis_tlast,
    input  logic [N_SRC-1:0]            s_axis_tvalid,
    output logic [N_SRC-1:0]            s_axis_tready,
    output logic [DWIDTH-1:0]           m_axis_tdata,
    output logic [DWIDTH/8-1:0]         m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [IDW-1:0]              m_axis_tid,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        locked
);

    localparam int KW = DWIDTH / 8;

    arb_state_t        r_state;
    arb_state_t        w_stateNext;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    w_ptrNext;
    logic [IDW-1:0]    r_grant;
    logic [IDW-1:0]    w_grantNext;

    logic [IDW-1:0]    w_pickIdx;
    logic              w_pickFound;
    logic [IDW-1:0]    w_sel;
    logic              w_selFound;
    logic              w_stageRdy;
    logic              w_acc;

    logic [DWIDTH-1:0] w_selData;
    logic [KW-1:0]     w_selKeep;
    logic              w_selLast;
    logic              w_selValid;

    logic [DWIDTH-1:0] r_mData;
    logic [KW-1:0]     r_mKeep;
    logic              r_mLast;
    logic [IDW-1:0]    r_mTid;
    logic              r_mValid;

    // Rotating search over the valid lines. It is used only while no packet is open.
    rifl_rr_pick #(
        .N_SRC (N_SRC),
        .IDW   (IDW)
    ) u_pick (
        .req   (s_axis_tvalid),
        .ptr   (r_ptr),
        .idx   (w_pickIdx),
        .found (w_pickFound)
    );

    // The output register can take a beat when it is empty or is being drained this cycle.
    assign w_stageRdy = m_axis_tready | ~r_mValid;

    // Pick the serviced source.
    // While locked, the grant is held even if its valid drops, so packets never interleave.
    always_comb begin
        w_sel      = w_pickIdx;
        w_selFound = w_pickFound;
        if (r_state == ARB_LOCKED) begin
            w_sel      = r_grant;
            w_selFound = 1'b1;
        end
    end

    // Route the selected source's beat toward the output register.
    always_comb begin
        w_selData  = '0;
        w_selKeep  = '0;
        w_selLast  = 1'b0;
        w_selValid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_sel == IDW'(i)) begin
                w_selData  = s_axis_tdata[i*DWIDTH +: DWIDTH];
                w_selKeep  = s_axis_tkeep[i*KW +: KW];
                w_selLast  = s_axis_tlast[i];
                w_selValid = s_axis_tvalid[i];
            end
        end
    end

    // Drive ready to the selected source only. All ready bits stay low while reset is held.
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!rst && w_stageRdy && w_selFound && (w_sel == IDW'(i))) begin
                s_axis_tready[i] = 1'b1;
            end
        end
    end

    assign w_acc = w_selValid & w_stageRdy & w_selFound & ~rst;

    // Next-state logic.
    // A non-last beat from IDLE opens a packet.
    // Any tlast beat closes the packet and moves priority past the sender.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_grantNext = r_grant;
        case (r_state)
            ARB_IDLE: begin
                if (w_acc) begin
                    if (w_selLast) begin
                        w_ptrNext = IDW'(rr_next(32'(w_sel), N_SRC));
                    end else begin
                        w_stateNext = ARB_LOCKED;
                        w_grantNext = w_sel;
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_acc && w_selLast) begin
                    w_stateNext = ARB_IDLE;
                    w_ptrNext   = IDW'(rr_next(32'(r_grant), N_SRC));
                end
            end
            default: begin
                w_stateNext = ARB_IDLE;
            end
        endcase
    end

    // Arbitration state registers. An asynchronous reset drops any open packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_grant <= w_grantNext;
        end
    end

    // Output stage.
    // Load on accept, clear valid when the beat drains, and hold everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mData  <= '0;
            r_mKeep  <= '0;
            r_mLast  <= 1'b0;
            r_mTid   <= '0;
            r_mValid <= 1'b0;
        end else if (w_acc) begin
            r_mData  <= w_selData;
            r_mKeep  <= w_selKeep;
            r_mLast  <= w_selLast;
            r_mTid   <= w_sel;
            r_mValid <= 1'b1;
        end else if (m_axis_tready) begin
            r_mValid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_mData;
    assign m_axis_tkeep  = r_mKeep;
    assign m_axis_tlast  = r_mLast;
    assign m_axis_tid    = r_mTid;
    assign m_axis_tvalid = r_mValid;
    assign locked        = (r_state == ARB_LOCKED);

endmodule

// File: tb/tb_rifl_axis_rr_arbiter.sv
// Self-checking bench for rifl_axis_rr_arbiter.
// Randomised sources are checked cycle by cycle against a packet-level round-robin reference model.
module tb_rifl_axis_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N-1:0]      s_axis_tlast;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [IDW-1:0]    m_axis_tid;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              locked;

    always #5 clk = ~clk;

    rifl_axis_rr_arbiter #(.N_SRC(N), .DWIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .locked        (locked)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Source-side stimulus state.
    logic [DW-1:0] srcData[N];
    logic [KW-1:0] srcKeep[N];
    bit            srcLast[N];
    bit            srcValid[N];
    int            srcBeatLeft[N];
    int            srcSeq[N];
    int            srcPkts[N];
    int            validPct;
    int            readyMode;
    int            fixLen;
    int            fifoCnt;
    int            dutHandshakes;
    bit            mReady;

    // Reference model: packet owner (-1 when free), priority pointer, and the expected output beat.
    int            mOwner;
    int            mPtr;
    bit            expValid;
    logic [DW-1:0] expData;
    logic [KW-1:0] expKeep;
    bit            expLast;
    int            expTid;
    int            curSel;
    bit            curFound;
    bit            curStageRdy;

    // Count one comparison and report it when it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic resetModel();
        mOwner   = -1;
        mPtr     = 0;
        expValid = 1'b0;
        expData  = '0;
        expKeep  = '0;
        expLast  = 1'b0;
        expTid   = 0;
        for (int s = 0; s < N; s++) begin
            srcValid[s]    = 1'b0;
            srcBeatLeft[s] = 0;
            srcPkts[s]     = 0;
            srcData[s]     = '0;
            srcKeep[s]     = '0;
            srcLast[s]     = 1'b0;
        end
    endtask

    // Present new source beats. A beat stays valid until accepted; gaps are allowed only between beats.
    task automatic applyStimulus();
        for (int s = 0; s < N; s++) begin
            if (!srcValid[s] && srcPkts[s] > 0 && $urandom_range(99) < validPct) begin
                if (srcBeatLeft[s] == 0) begin
                    srcBeatLeft[s] = (fixLen > 0) ? fixLen : int'($urandom_range(1, 5));
                end
                srcData[s]  = {8'(s), 24'(srcSeq[s])};
                srcKeep[s]  = 4'($urandom_range(1, 15));
                srcLast[s]  = (srcBeatLeft[s] == 1);
                srcValid[s] = 1'b1;
            end
        end
        case (readyMode)
            0:       mReady = 1'b1;
            1:       mReady = ($urandom_range(99) < 65);
            default: mReady = (fifoCnt < 4);
        endcase
        for (int s = 0; s < N; s++) begin
            s_axis_tdata[s*DW +: DW] = srcData[s];
            s_axis_tkeep[s*KW +: KW] = srcKeep[s];
            s_axis_tlast[s]          = srcLast[s];
            s_axis_tvalid[s]         = srcValid[s];
        end
        m_axis_tready = mReady;
    endtask

    // Round-robin rule: the packet owner if one exists, else the first valid source at or after the pointer.
    task automatic modelSelect();
        curFound = 1'b0;
        curSel   = 0;
        if (mOwner >= 0) begin
            curSel   = mOwner;
            curFound = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mPtr + k) % N;
                if (!curFound && srcValid[c]) begin
                    curSel   = c;
                    curFound = 1'b1;
                end
            end
        end
        curStageRdy = mReady || !expValid;
    endtask

    task automatic sampleAndCheck();
        logic [N-1:0] expReady;
        modelSelect();
        expReady = '0;
        if (curFound && curStageRdy) begin
            expReady[curSel] = 1'b1;
        end
        checkOutput("tready", 64'(s_axis_tready), 64'(expReady));
        checkOutput("mValid", 64'(m_axis_tvalid), 64'(expValid));
        checkOutput("locked", 64'(locked), 64'(mOwner >= 0));
        if (expValid) begin
            checkOutput("mData", 64'(m_axis_tdata), 64'(expData));
            checkOutput("mKeep", 64'(m_axis_tkeep), 64'(expKeep));
            checkOutput("mLast", 64'(m_axis_tlast), 64'(expLast));
            checkOutput("mTid",  64'(m_axis_tid),   64'(expTid));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            dutHandshakes++;
        end
    endtask

    task automatic updateModel();
        bit acc;
        acc = curFound && curStageRdy && srcValid[curSel];
        if (expValid && mReady) begin
            fifoCnt++;
        end
        if (acc) begin
            expValid = 1'b1;
            expData  = srcData[curSel];
            expKeep  = srcKeep[curSel];
            expLast  = srcLast[curSel];
            expTid   = curSel;
            if (srcLast[curSel]) begin
                mOwner = -1;
                mPtr   = (curSel + 1) % N;
                srcPkts[curSel]--;
            end else begin
                mOwner = curSel;
            end
            srcValid[curSel] = 1'b0;
            srcBeatLeft[curSel]--;
            srcSeq[curSel]++;
        end else if (mReady) begin
            expValid = 1'b0;
        end
    endtask

    task automatic runCycle();
        @(negedge clk);
        applyStimulus();
        #1;
        sampleAndCheck();
        @(posedge clk);
        updateModel();
    endtask

    function automatic bit pending();
        bit p;
        p = expValid;
        for (int s = 0; s < N; s++) begin
            if (srcPkts[s] > 0 || srcValid[s]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            runCycle();
            n++;
        end
        if (n >= budget) begin
            checkOutput("drainTimeout", 64'd0, 64'd1);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mValid"}, 64'(m_axis_tvalid), 64'd0);
        checkOutput({tag, "_locked"}, 64'(locked), 64'd0);
        checkOutput({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
        checkOutput({tag, "_mData"},  64'(m_axis_tdata), 64'd0);
        checkOutput({tag, "_mTid"},   64'(m_axis_tid), 64'd0);
    endtask

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int s = 0; s < N; s++) srcSeq[s] = 0;
        resetModel();
        validPct  = 100;
        readyMode = 0;
        fixLen    = 0;
        fifoCnt   = 0;
        dutHandshakes = 0;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '1;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        s_axis_tvalid = '0;
        rst = 1'b0;

        $display("[TB] single source, 3-beat packet from source 2");
        srcPkts[2] = 1; fixLen = 3; validPct = 100; readyMode = 0;
        drain(100);

        $display("[TB] fairness with single-beat packets from all sources");
        for (int s = 0; s < N; s++) srcPkts[s] = 4;
        fixLen = 1;
        drain(200);

        $display("[TB] random packets, gaps and backpressure");
        for (int s = 0; s < N; s++) srcPkts[s] = 8;
        fixLen = 0; validPct = 60; readyMode = 1;
        drain(3000);

        $display("[TB] stalled depth-4 consumer");
        for (int s = 0; s < N; s++) srcPkts[s] = 2;
        validPct = 100; readyMode = 2; fifoCnt = 0; dutHandshakes = 0;
        repeat (20) runCycle();
        checkOutput("fifoAccepted", 64'(dutHandshakes), 64'd4);
        readyMode = 0;
        drain(500);

        $display("[TB] asynchronous reset mid-packet");
        srcPkts[0] = 1; fixLen = 5; validPct = 100; readyMode = 0;
        repeat (2) runCycle();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRst_mValid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("midRst_locked", 64'(locked), 64'd0);
        checkOutput("midRst_tready", 64'(s_axis_tready), 64'd0);
        resetModel();
        s_axis_tvalid = '0;
        @(posedge clk);
        @(negedge clk);
        checkResetState("midRstHeld");
        rst = 1'b0;
        srcPkts[3] = 1; fixLen = 2;
        drain(100);

        $display("[TB] second random pass");
        for (int s = 0; s < N; s++) srcPkts[s] = 6;
        fixLen = 0; validPct = 80; readyMode = 1;
        drain(3000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rifl_axis_rr_arbiter.md
# rifl_axis_rr_arbiter

Packet-atomic round-robin arbiter that merges N_SRC AXI-Stream sources into a single AXI-Stream output, normally feeding a `rifl_axis_sync_fifo` that is shared between several lane or user producers. Once a source wins, the grant is held until its `tlast` beat is accepted, so packets are never interleaved. The output is registered. A source-ID sideband travels with each beat so the consumer can demultiplex.

## Interface
Parameters:
- `N_SRC`, default 4: number of input streams; legal range ≥2.
- `DWIDTH`, default 32: tdata width in bits; a multiple of 8.
- `IDW`, default `$clog2(N_SRC)`: width of the source-ID field.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  N_SRC*DWIDTH  source i occupies slice [i*DWIDTH +: DWIDTH].
- `s_axis_tkeep`  in  N_SRC*DWIDTH/8  source i occupies slice [i*DWIDTH/8 +: DWIDTH/8].
- `s_axis_tlast`  in  N_SRC  one bit per source.
- `s_axis_tvalid`  in  N_SRC  one bit per source.
- `s_axis_tready`  out  N_SRC  at most one bit high in any cycle.
- `m_axis_tdata`  out  DWIDTH  merged data.
- `m_axis_tkeep`  out  DWIDTH/8  merged keep.
- `m_axis_tlast`  out  1  merged last.
- `m_axis_tid`  out  IDW  index of the source that produced the beat.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `locked`  out  1  high while a packet is in progress (state ARB_LOCKED).

## Operation
- State machine `arb_state_t` has two states.
  - ARB_IDLE: no packet is open.
  - ARB_LOCKED: mid-packet; only `grant` is served.
- Registers:
  - `state`
  - `ptr` [IDW]: highest-priority index for the next arbitration.
  - `grant` [IDW]
  - output stage: `m_axis_*` registers.
- Stage readiness: `stage_rdy = m_axis_tready | ~m_axis_tvalid`.
- Selection `sel`:
  - In ARB_IDLE, `sel` is the first i with `s_axis_tvalid[i]=1`, scanning ptr, ptr+1, … modulo N_SRC. The search is combinational, with no arbitration bubble.
  - In ARB_LOCKED, `sel = grant`. Other sources are ignored even when the granted source drops tvalid mid-packet; the arbiter waits.
- Ready: `s_axis_tready[i] = stage_rdy & (i==sel) & sel_found`. In ARB_LOCKED, `sel_found` is always 1.
- Accept: `acc = s_axis_tvalid[sel] & s_axis_tready[sel]`.
- Transitions on acc:
  - ARB_IDLE, beat not tlast: go to ARB_LOCKED with `grant <= sel`.
  - ARB_IDLE, single-beat packet (tlast): stay in ARB_IDLE with `ptr <= sel+1 mod N_SRC`.
  - ARB_LOCKED, beat is tlast: go to ARB_IDLE with `ptr <= grant+1 mod N_SRC`.
- Wrap-around: `ptr` increments modulo N_SRC, so `ptr = N_SRC-1` wraps to 0. `N_SRC` may be a non-power-of-2, so use an explicit compare, not bit truncation.
- Output stage:
  - On acc, load the data, keep, last, `tid=sel` and `tvalid=1`.
  - Else, if `m_axis_tready` is high, set `tvalid <= 0`.
- Reset (asynchronous, mid-packet included):
  - Clears `state` to ARB_IDLE and `ptr`, `grant` to 0.
  - Clears all `m_axis_*` outputs to 0.
  - A partially forwarded packet is discarded without a terminating beat; upstream is also reset.
- While `rst` is high, all `s_axis_tready` bits are 0.

## Timing
- Latency: a beat accepted at edge k appears on `m_axis_*` after edge k.
- Throughput: full rate, one beat per cycle, including back-to-back packets from different sources. There is no dead cycle at a packet boundary.
- `s_axis_tready` depends combinationally on `m_axis_tready` through `stage_rdy`. This is the same ready path as the `OUTPUT_REG` mode of the FIFO, so there is no extra skid stage.
- Outputs hold stable while `m_axis_tvalid=1` and `m_axis_tready=0`, per AXI-Stream.
- Arbitration fairness: each requesting source waits at most N_SRC-1 packets.

## Structure
- Package `rifl_arb_pkg` contains:
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t`.
  - A function `rr_next(ptr, n)` returning ptr+1 mod n.
- Sub-module `rifl_rr_pick` is a combinational rotating priority encoder.
  - Parameter: N_SRC.
  - Inputs: `req[N_SRC]`, `ptr[IDW]`.
  - Outputs: `idx[IDW]`, `found`.
  - It is reusable by other RIFL schedulers.

## Test plan
- Single source: source 2 sends 3-beat packet A0..A2 with `m_axis_tready=1`. Required: beats appear on cycles +1..+3 with `tid=2` and `tlast` on A2; after that `ptr=3`.
- Fairness and wrap: all 4 sources continuously send single-beat packets. Required: `tid` sequence 0,1,2,3,0,1,… with no idle cycles.
- Packet lock: source 0 sends a 4-beat packet and drops tvalid for 2 cycles after beat 1, while source 1 is valid throughout. Required: `s_axis_tready[1]=0` until source 0's tlast is accepted; source 1's packet follows immediately.
- Backpressure: toggle `m_axis_tready` 1,0,0,1 mid-packet. Required: output data is held stable on the stall cycles, no beat is lost or duplicated, and beat order matches the input order.
- Reset mid-packet: assert `rst` asynchronously between clock edges during beat 2 of 5. Required: `m_axis_tvalid=0`, `locked=0` and `s_axis_tready=0` immediately. After release, a new packet from source 3 is arbitrated from `ptr=0` and appears on the output with `tid=3`.
- Into the FIFO: drive the output into `rifl_axis_sync_fifo` with `DEPTH=4` and hold the FIFO read side stalled. Required: exactly 4 beats are accepted, then all `s_axis_tready` go to 0; on resuming, the data sequence is intact.
